inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader.sv | 127 ++++++++++++
 tb/tb_inst_mem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - boot-time byte-stream loader that fills instruction memory and releases the core
// Optional trailing checksum byte: define INST_LOADER_CHECKSUM_EN
module inst_mem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;
    localparam state_t FINAL_ST = CHK;
`else
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
    localparam state_t FINAL_ST = DONE;
`endif

    localparam logic [ADDR_W:0] WL_MAX = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] WL_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t      state, next_state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] len_next;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic        accept;
    logic        last_byte;
    logic        last_word;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    assign accept    = in_valid && in_ready;
    assign len_next  = {len_hi, in_byte};
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = ((word_idx + 16'd1) == len);

    always_comb begin
        next_state = state;
        case (state)
            LEN_HI: if (accept) next_state = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (32'(len_next) > MAX_WORDS) next_state = ERR;
                    else if (len_next == 16'd0)    next_state = FINAL_ST;
                    else                           next_state = DATA;
                end
            end
            DATA: if (accept && last_byte && last_word) next_state = FINAL_ST;
`ifdef INST_LOADER_CHECKSUM_EN
            CHK: if (accept) next_state = (in_byte == sum) ? DONE : ERR;
`endif
            default: next_state = state;
        endcase
    end

    // Status flags are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LEN_HI;
            in_ready <= 1'b1;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != DONE) && (next_state != ERR);
            cpu_rst  <= (next_state != DONE);
            done     <= (next_state == DONE);
            error    <= (next_state == ERR);
        end
    end

    // mem_we doubles as the write-pending flag: set on the 4th byte, cleared the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            len_hi       <= '0;
            len          <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (mem_we && (words_loaded != WL_MAX))
                words_loaded <= words_loaded + WL_ONE;
            if (accept) begin
                case (state)
                    LEN_HI: len_hi <= in_byte;
                    LEN_LO: len    <= len_next;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_q    <= {asm_q[15:0], in_byte};
`ifdef INST_LOADER_CHECKSUM_EN
                        sum      <= sum + in_byte;
`endif
                        if (last_byte) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= {asm_q, in_byte};
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed, table-driven bench for inst_mem_loader
module tb_inst_mem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    typedef struct {
        logic              v;
        logic [7:0]        b;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              rdy;
        logic              crst;
        logic              dn;
        logic              er;
        logic [ADDR_W:0]   wl;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    function automatic vec_t mk(input logic v, input logic [7:0] b, input logic we,
                                input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                input logic rdy, input logic crst, input logic dn,
                                input logic er, input logic [ADDR_W:0] wl);
        vec_t r;
        r.v = v; r.b = b; r.we = we; r.addr = addr; r.wdata = wdata;
        r.rdy = rdy; r.crst = crst; r.dn = dn; r.er = er; r.wl = wl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t e);
        chk({tag, ".mem_we"},       32'(mem_we),       32'(e.we));
        chk({tag, ".mem_addr"},     32'(mem_addr),     32'(e.addr));
        chk({tag, ".mem_wdata"},    mem_wdata,         e.wdata);
        chk({tag, ".in_ready"},     32'(in_ready),     32'(e.rdy));
        chk({tag, ".cpu_rst"},      32'(cpu_rst),      32'(e.crst));
        chk({tag, ".done"},         32'(done),         32'(e.dn));
        chk({tag, ".error"},        32'(error),        32'(e.er));
        chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(e.wl));
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        in_valid = v;
        in_byte  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send(input logic [7:0] s[$], input bit gaps, input string tag);
        foreach (s[i]) begin
            if (gaps) begin
                step(1'b0, 8'hAA);
                chk($sformatf("%s.gap_ready[%0d]", tag, i), 32'(in_ready), 32'd1);
            end
            step(1'b1, s[i]);
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
    endtask

    task automatic expect_writes(input string tag, input int n,
                                 input logic [ADDR_W-1:0] a0, input logic [31:0] d0,
                                 input logic [ADDR_W-1:0] a1, input logic [31:0] d1);
        chk({tag, ".write_count"}, 32'(wr_addr.size()), 32'(n));
        if (n > 0 && wr_addr.size() > 0) begin
            chk({tag, ".w0_addr"}, 32'(wr_addr[0]), 32'(a0));
            chk({tag, ".w0_data"}, wr_data[0], d0);
        end
        if (n > 1 && wr_addr.size() > 1) begin
            chk({tag, ".w1_addr"}, 32'(wr_addr[1]), 32'(a1));
            chk({tag, ".w1_data"}, wr_data[1], d1);
        end
    endtask

    initial begin
        logic [7:0] s2[$];
        logic [7:0] s5[$];
        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'h00;

        do_reset();
        chk_vec("reset", mk(1'b0, 8'h00, 1'b0, '0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, '0));

        // Two-word image, in_valid held high, one output vector per accepted byte.
        tbl.push_back(mk(1, 8'h00, 0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h08, 0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h05, 1, 0, 32'h20080005, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 32'h20080005, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h09, 0, 0, 32'h20080005, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h00, 0, 0, 32'h20080005, 1, 1, 0, 0, 1));
`ifdef INST_LOADER_CHECKSUM_EN
        tbl.push_back(mk(1, 8'h07, 1, 1, 32'h20090007, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h5D, 0, 1, 32'h20090007, 0, 0, 1, 0, 2));
`else
        tbl.push_back(mk(1, 8'h07, 1, 1, 32'h20090007, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 8'hFF, 0, 1, 32'h20090007, 0, 0, 1, 0, 2));
`endif
        tbl.push_back(mk(1, 8'hEE, 0, 1, 32'h20090007, 0, 0, 1, 0, 2));
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].b);
            chk_vec($sformatf("t1[%0d]", i), tbl[i]);
        end
        expect_writes("t1", 2, 0, 32'h20080005, 1, 32'h20090007);

        // Same image with idle cycles between bytes.
        s2 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
`ifdef INST_LOADER_CHECKSUM_EN
        s2.push_back(8'h5D);
`endif
        do_reset();
        send(s2, 1'b1, "t2");
        expect_writes("t2", 2, 0, 32'h20080005, 1, 32'h20090007);
        chk_vec("t2.end", mk(0, 8'h00, 0, 1, 32'h20090007, 0, 0, 1, 0, 2));

        // Oversized length 1025.
        do_reset();
        step(1'b1, 8'h04);
        step(1'b1, 8'h01);
        chk_vec("t3.err", mk(0, 8'h00, 0, 0, 32'h0, 0, 1, 0, 1, 0));
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00);
        chk_vec("t3.hold", mk(0, 8'h00, 0, 0, 32'h0, 0, 1, 0, 1, 0));
        expect_writes("t3", 0, 0, 32'h0, 0, 32'h0);

        // Empty image.
        do_reset();
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
`ifdef INST_LOADER_CHECKSUM_EN
        chk_vec("t4.chk", mk(0, 8'h00, 0, 0, 32'h0, 1, 1, 0, 0, 0));
        step(1'b1, 8'h00);
        chk_vec("t4.ok", mk(0, 8'h00, 0, 0, 32'h0, 0, 0, 1, 0, 0));
        do_reset();
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h01);
        chk_vec("t4.bad", mk(0, 8'h00, 0, 0, 32'h0, 0, 1, 0, 1, 0));
`else
        chk_vec("t4.done", mk(0, 8'h00, 0, 0, 32'h0, 0, 0, 1, 0, 0));
`endif
        step(1'b0, 8'h00);
        expect_writes("t4", 0, 0, 32'h0, 0, 32'h0);

`ifdef INST_LOADER_CHECKSUM_EN
        // Single word with good and bad checksum.
        s5 = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
        do_reset();
        send(s5, 1'b0, "t5a");
        chk_vec("t5a.end", mk(0, 8'h00, 0, 0, 32'h12345678, 0, 0, 1, 0, 1));
        expect_writes("t5a", 1, 0, 32'h12345678, 0, 32'h0);
        s5[6] = 8'h15;
        do_reset();
        send(s5, 1'b0, "t5b");
        chk_vec("t5b.end", mk(0, 8'h00, 0, 0, 32'h12345678, 0, 1, 0, 1, 1));
        expect_writes("t5b", 1, 0, 32'h12345678, 0, 32'h0);
`else
        s5 = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        do_reset();
        send(s5, 1'b0, "t5");
        chk_vec("t5.end", mk(0, 8'h00, 0, 0, 32'h12345678, 0, 0, 1, 0, 1));
        expect_writes("t5", 1, 0, 32'h12345678, 0, 32'h0);
`endif

        // Reset in the middle of a load, then a full reload.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, s2[i]);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h05;
        @(posedge clk);
        #1;
        chk_vec("t6.rst", mk(0, 8'h00, 0, 0, 32'h0, 1, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        send(s2, 1'b0, "t6");
        expect_writes("t6", 2, 0, 32'h20080005, 1, 32'h20090007);
        chk_vec("t6.end", mk(0, 8'h00, 0, 1, 32'h20090007, 0, 0, 1, 0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
